// File: rtl/stm32_bus_pkg.sv
// ============================================================================
// Module  : stm32_bus_pkg
// Purpose : Shared types and constants for the 8-bit STM32<->FPGA command bus
//           (state encoding, transfer-mode codes, command opcodes, and the
//           per-byte direction rule).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package stm32_bus_pkg;

  // Initiator sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC_LO = 3'd1,
    ST_SYNC_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_STALL   = 3'd4,
    ST_DATA_HI = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Transfer-mode codes carried on req_mode
  localparam logic [1:0] MODE_WRITE = 2'd0;
  localparam logic [1:0] MODE_READ  = 2'd1;
  localparam logic [1:0] MODE_ALT   = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  // Command opcodes understood by responders on this bus
  localparam logic [7:0] CMD_BUS_TEST    = 8'h00;
  localparam logic [7:0] CMD_GET_PARAMS  = 8'h01;
  localparam logic [7:0] CMD_SEND_PARAMS = 8'h02;
  localparam logic [7:0] CMD_TX_IQ       = 8'h03;
  localparam logic [7:0] CMD_RX_IQ       = 8'h04;
  localparam logic [7:0] CMD_RESET_ON    = 8'h05;
  localparam logic [7:0] CMD_RESET_OFF   = 8'h06;
  localparam logic [7:0] CMD_FLASH_READ  = 8'h07;
  localparam logic [7:0] CMD_GET_INFO    = 8'h08;

  // Direction of data byte idx: 1 = initiator writes, 0 = initiator reads.
  // The reserved mode behaves like all-write.
  function automatic logic byte_is_write(input logic [1:0] mode,
                                         input logic [7:0] idx);
    logic w;
    case (mode)
      MODE_READ: w = 1'b0;
      MODE_ALT:  w = ~idx[0];
      default:   w = 1'b1;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stm32_bus_initiator.sv
// ============================================================================
// Module  : stm32_bus_initiator
// Purpose : Host end of the 8-bit parallel STM32<->FPGA command bus. Issues a
//           command byte under DATA_SYNC, then streams len data bytes, each
//           written from the wr_* stream or captured to the rd_* stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stm32_bus_initiator
  import stm32_bus_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_len,
  input  logic [1:0] req_mode,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       BUS_CLK,
  output logic       DATA_SYNC,
  inout  wire  [7:0] DATA_BUS
);

  localparam int unsigned    CNT_W    = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       len_q, len_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       dout_q, dout_d;
  logic             oe_q, oe_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             req_ready_q, req_ready_d;

  logic             phase_end;
  logic             cur_wr;
  logic [7:0]       idx_next;
  logic             last_byte;
  logic             next_wr;
  logic             accept;
  logic             wr_hs;

  assign phase_end = (cnt_q == CNT_LAST);
  assign cur_wr    = byte_is_write(mode_q, idx_q);
  assign idx_next  = idx_q + 8'd1;
  assign last_byte = (idx_next == len_q);
  assign next_wr   = byte_is_write(mode_q, idx_next);
  assign accept    = req_valid && req_ready_q && (state_q == ST_IDLE);
  assign wr_hs     = wr_valid && wr_ready;

  // The handshake cycle already counts as the first stable LO cycle, so the
  // incoming byte is put on the bus combinationally until it is registered.
  assign DATA_BUS = (oe_q || wr_hs) ? (wr_hs ? wr_data : dout_q) : 8'hzz;

  // State and datapath registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      mode_q      <= MODE_WRITE;
      dout_q      <= '0;
      oe_q        <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Next-state, phase counting, bus-drive and capture decisions
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    mode_d     = mode_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        oe_d = 1'b0;
        if (accept) begin
          state_d = ST_SYNC_LO;
          cnt_d   = '0;
          len_d   = req_len;
          mode_d  = (req_mode == MODE_RSVD) ? MODE_WRITE : req_mode;
          dout_d  = req_cmd;
          oe_d    = 1'b1;
        end
      end

      ST_SYNC_LO: begin
        cnt_d = cnt_q + CNT_ONE;
        if (phase_end) begin
          state_d = ST_SYNC_HI;
          cnt_d   = '0;
        end
      end

      ST_SYNC_HI: begin
        cnt_d = cnt_q + CNT_ONE;
        // Hold the command one cycle past the edge, then release unless
        // byte 0 is ours to drive.
        if (cnt_q == '0 && (len_q == 8'd0 || !byte_is_write(mode_q, 8'd0)))
          oe_d = 1'b0;
        if (phase_end) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = (len_q == 8'd0) ? ST_DONE : ST_DATA_LO;
        end
      end

      ST_DATA_LO: begin
        if (cur_wr && cnt_q == '0 && !wr_valid) begin
          state_d = ST_STALL;
        end else begin
          if (wr_hs) begin
            dout_d = wr_data;
            oe_d   = 1'b1;
          end
          cnt_d = cnt_q + CNT_ONE;
          if (phase_end) begin
            state_d = ST_DATA_HI;
            cnt_d   = '0;
          end
        end
      end

      ST_STALL: begin
        // Bus clock frozen low; the handshake cycle is LO count 0.
        if (wr_valid) begin
          dout_d  = wr_data;
          oe_d    = 1'b1;
          state_d = ST_DATA_LO;
          cnt_d   = CNT_ONE;
        end
      end

      ST_DATA_HI: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == '0 && (last_byte || !next_wr))
          oe_d = 1'b0;
        if (phase_end) begin
          cnt_d = '0;
          if (!cur_wr) begin
            rd_data_d  = DATA_BUS;
            rd_valid_d = 1'b1;
          end
          idx_d   = idx_next;
          state_d = last_byte ? ST_DONE : ST_DATA_LO;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  // Registered so req_ready stays low while reset is held
  assign req_ready_d = (state_d == ST_IDLE);

  // Moore outputs decoded from the current state
  always_comb begin
    BUS_CLK   = (state_q == ST_SYNC_HI) || (state_q == ST_DATA_HI);
    DATA_SYNC = (state_q == ST_SYNC_LO) || (state_q == ST_SYNC_HI);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    wr_ready  = ((state_q == ST_DATA_LO) && cur_wr && (cnt_q == '0)) ||
                (state_q == ST_STALL);
    rd_data   = rd_data_q;
    rd_valid  = rd_valid_q;
    req_ready = req_ready_q;
  end

endmodule

`default_nettype wire
